// File: rtl/alu_pipe_pkg.sv
// Shared ALU definitions: funct3 group encodings, SUB/SRA select bit position and
// the legality rule for the OP-32 word forms.
package alu_pipe_pkg;

  localparam logic [2:0] ALU_ADD_SUB = 3'b000;
  localparam logic [2:0] ALU_SLL     = 3'b001;
  localparam logic [2:0] ALU_SLT     = 3'b010;
  localparam logic [2:0] ALU_SLTU    = 3'b011;
  localparam logic [2:0] ALU_XOR     = 3'b100;
  localparam logic [2:0] ALU_SHIFTR  = 3'b101;
  localparam logic [2:0] ALU_OR      = 3'b110;
  localparam logic [2:0] ALU_AND     = 3'b111;

  // Bit of alu_funct that turns ADD into SUB and SRL into SRA.
  localparam int unsigned ALU_ALT_BIT = 3;

  // Only ADD/SUB and the shifts have OP-32 encodings.
  function automatic logic word_legal(input logic [2:0] grp);
    return (grp == ALU_ADD_SUB) || (grp == ALU_SLL) || (grp == ALU_SHIFTR);
  endfunction

endpackage

// File: rtl/alu_core.sv
// Purely combinational RV64I/RV32I OP/OP-IMM compute, including the OP-32 word forms.
module alu_core
  import alu_pipe_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic [3:0]      alu_funct,
  input  logic            word_mode,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  output logic [XLEN-1:0] result,
  output logic            illegal
);

  localparam int unsigned ShW = (XLEN == 64) ? 6 : 5;

  logic [2:0]      grp;
  logic            alt;
  logic            word_en;
  logic [ShW-1:0]  shamt;
  logic [4:0]      shamt_w;
  logic [31:0]     a_w;
  logic [31:0]     b_w;
  logic [XLEN-1:0] full_res;
  logic [31:0]     word_res;

  assign grp     = alu_funct[2:0];
  assign alt     = alu_funct[ALU_ALT_BIT];
  assign word_en = word_mode && (XLEN == 64);
  assign shamt   = operand_b[ShW-1:0];
  assign shamt_w = operand_b[4:0];
  assign a_w     = operand_a[31:0];
  assign b_w     = operand_b[31:0];

  always_comb begin
    full_res = '0;
    case (grp)
      ALU_ADD_SUB: full_res = alt ? (operand_a - operand_b) : (operand_a + operand_b);
      ALU_SLL:     full_res = operand_a << shamt;
      ALU_SLT:     full_res = {{(XLEN-1){1'b0}}, ($signed(operand_a) < $signed(operand_b))};
      ALU_SLTU:    full_res = {{(XLEN-1){1'b0}}, (operand_a < operand_b)};
      ALU_XOR:     full_res = operand_a ^ operand_b;
      ALU_SHIFTR:  full_res = alt ? $unsigned($signed(operand_a) >>> shamt)
                                  : (operand_a >> shamt);
      ALU_OR:      full_res = operand_a | operand_b;
      ALU_AND:     full_res = operand_a & operand_b;
      default:     full_res = '0;
    endcase
  end

  always_comb begin
    word_res = '0;
    case (grp)
      ALU_ADD_SUB: word_res = alt ? (a_w - b_w) : (a_w + b_w);
      ALU_SLL:     word_res = a_w << shamt_w;
      ALU_SHIFTR:  word_res = alt ? $unsigned($signed(a_w) >>> shamt_w) : (a_w >> shamt_w);
      default:     word_res = '0;
    endcase
  end

  // Word results are sign-extended from bit 31; undefined word groups read as zero.
  always_comb begin
    result  = full_res;
    illegal = 1'b0;
    if (word_en) begin
      illegal = !word_legal(grp);
      result  = illegal ? '0 : XLEN'($signed(word_res));
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Pipelined EX-stage ALU: optional operand register, result register, valid/ready on
// both sides, pass-through tag and synchronous flush.
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned STAGES = 1,
  parameter int unsigned TAG_W  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_funct,
  input  logic             word_mode,
  input  logic [XLEN-1:0]  operand_a,
  input  logic [XLEN-1:0]  operand_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  if (!(XLEN == 32 || XLEN == 64)) begin : g_bad_xlen
    $error("alu_pipe: XLEN must be 32 or 64");
  end

  // Operands presented to the compute core (from the ports or the operand register).
  logic             core_valid;
  logic [3:0]       core_funct;
  logic             core_word;
  logic [XLEN-1:0]  core_a;
  logic [XLEN-1:0]  core_b;
  logic [TAG_W-1:0] core_tag;
  logic [XLEN-1:0]  core_result;
  logic             core_illegal;

  logic             res_valid_q;
  logic [XLEN-1:0]  res_result_q;
  logic [TAG_W-1:0] res_tag_q;
  logic             res_illegal_q;
  logic             res_ready;
  logic             res_load;

  alu_core #(
    .XLEN (XLEN)
  ) u_core (
    .alu_funct (core_funct),
    .word_mode (core_word),
    .operand_a (core_a),
    .operand_b (core_b),
    .result    (core_result),
    .illegal   (core_illegal)
  );

  if (STAGES == 1) begin : g_one_stage
    assign core_valid = in_valid;
    assign core_funct = alu_funct;
    assign core_word  = word_mode;
    assign core_a     = operand_a;
    assign core_b     = operand_b;
    assign core_tag   = in_tag;
    assign in_ready   = res_ready;
  end else if (STAGES == 2) begin : g_two_stage
    logic             op_valid_q;
    logic [3:0]       op_funct_q;
    logic             op_word_q;
    logic [XLEN-1:0]  op_a_q;
    logic [XLEN-1:0]  op_b_q;
    logic [TAG_W-1:0] op_tag_q;
    logic             op_load;

    assign in_ready = !op_valid_q || res_ready;
    assign op_load  = in_valid && in_ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        op_valid_q <= 1'b0;
        op_funct_q <= '0;
        op_word_q  <= 1'b0;
        op_a_q     <= '0;
        op_b_q     <= '0;
        op_tag_q   <= '0;
      end else begin
        if (flush) begin
          op_valid_q <= 1'b0;
        end else if (in_ready) begin
          op_valid_q <= in_valid;
        end
        if (op_load) begin
          op_funct_q <= alu_funct;
          op_word_q  <= word_mode;
          op_a_q     <= operand_a;
          op_b_q     <= operand_b;
          op_tag_q   <= in_tag;
        end
      end
    end

    assign core_valid = op_valid_q;
    assign core_funct = op_funct_q;
    assign core_word  = op_word_q;
    assign core_a     = op_a_q;
    assign core_b     = op_b_q;
    assign core_tag   = op_tag_q;
  end else begin : g_bad_stages
    $error("alu_pipe: STAGES must be 1 or 2");
  end

  assign res_ready = !res_valid_q || out_ready;
  assign res_load  = core_valid && res_ready && !flush;

  // Payload only moves on a real transfer, so a stalled result holds steady.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_q   <= 1'b0;
      res_result_q  <= '0;
      res_tag_q     <= '0;
      res_illegal_q <= 1'b0;
    end else begin
      if (flush) begin
        res_valid_q <= 1'b0;
      end else if (res_ready) begin
        res_valid_q <= core_valid;
      end
      if (res_load) begin
        res_result_q  <= core_result;
        res_tag_q     <= core_tag;
        res_illegal_q <= core_illegal;
      end
    end
  end

  assign out_valid   = res_valid_q;
  assign out_result  = res_result_q;
  assign out_tag     = res_tag_q;
  assign out_illegal = res_illegal_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe (XLEN=64, STAGES=2): directed vectors, back-pressure,
// flush and mid-stream reset.
module tb_alu_pipe;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned STAGES = 2;
  localparam int unsigned TAG_W  = 5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [3:0]       alu_funct = '0;
  logic             word_mode = 1'b0;
  logic [XLEN-1:0]  operand_a = '0;
  logic [XLEN-1:0]  operand_b = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [XLEN-1:0]  out_result;
  logic [TAG_W-1:0] out_tag;
  logic             out_illegal;

  typedef struct packed {
    logic [63:0] res;
    logic [4:0]  tag;
    logic        ill;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 1'b0;
  int          popped = 0;
  bit          saw_stall = 1'b0;
  logic        prev_hold = 1'b0;
  logic [63:0] prev_res = '0;
  logic [4:0]  prev_tag = '0;

  always #5 clk = ~clk;

  alu_pipe #(
    .XLEN   (XLEN),
    .STAGES (STAGES),
    .TAG_W  (TAG_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_funct   (alu_funct),
    .word_mode   (word_mode),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .in_tag      (in_tag),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_tag     (out_tag),
    .out_illegal (out_illegal)
  );

  // Output monitor: inputs only change on negedge, so a sample at negedge+2 is what the
  // following posedge will see.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (mon_en && rst_n) begin
      if (prev_hold) begin
        checks++;
        if (out_valid !== 1'b1 || out_result !== prev_res || out_tag !== prev_tag) begin
          errors++;
          $display("FAIL stall_hold got v=%b res=%h tag=%h exp v=1 res=%h tag=%h",
                   out_valid, out_result, out_tag, prev_res, prev_tag);
        end
      end
      if (!in_ready) saw_stall = 1'b1;
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_result got res=%h tag=%h exp none", out_result, out_tag);
        end else begin
          e = sb.pop_front();
          popped++;
          if (out_result !== e.res || out_tag !== e.tag || out_illegal !== e.ill) begin
            errors++;
            $display("FAIL result got res=%h tag=%h ill=%b exp res=%h tag=%h ill=%b",
                     out_result, out_tag, out_illegal, e.res, e.tag, e.ill);
          end
        end
      end
      prev_hold = out_valid && !out_ready;
      prev_res  = out_result;
      prev_tag  = out_tag;
    end else begin
      prev_hold = 1'b0;
    end
  end

  task automatic send(input logic [3:0] f, input logic w, input logic [63:0] a,
                      input logic [63:0] b, input logic [4:0] t, input logic [63:0] er,
                      input logic ei, input bit push);
    int   n;
    exp_t e;
    @(negedge clk);
    alu_funct = f;
    word_mode = w;
    operand_a = a;
    operand_b = b;
    in_tag    = t;
    in_valid  = 1'b1;
    #1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout got in_ready=0 exp in_ready=1 tag=%h", t);
    end else if (push) begin
      e.res = er;
      e.tag = t;
      e.ill = ei;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain got pending=%0d exp pending=0", sb.size());
    end
  endtask

  // Directed op on an empty pipe: checks the STAGES-cycle latency explicitly.
  task automatic direct_op(input logic [3:0] f, input logic w, input logic [63:0] a,
                           input logic [63:0] b, input logic [4:0] t, input logic [63:0] er,
                           input logic ei);
    @(negedge clk);
    alu_funct = f;
    word_mode = w;
    operand_a = a;
    operand_b = b;
    in_tag    = t;
    in_valid  = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL lat_in_ready got %b exp 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL lat_early got out_valid=%b exp 0", out_valid);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_result !== er || out_tag !== t || out_illegal !== ei) begin
      errors++;
      $display("FAIL lat_result got v=%b res=%h tag=%h ill=%b exp v=1 res=%h tag=%h ill=%b",
               out_valid, out_result, out_tag, out_illegal, er, t, ei);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL lat_consumed got out_valid=%b exp 0", out_valid);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if (out_valid !== 1'b0 || out_result !== 64'h0 || out_tag !== 5'h0 || out_illegal !== 1'b0)
    begin
      errors++;
      $display("FAIL %s got v=%b res=%h tag=%h ill=%b exp all zero",
               name, out_valid, out_result, out_tag, out_illegal);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    check_idle_outputs("reset_outputs");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %b exp 1", in_ready);
    end
    check_idle_outputs("post_reset_outputs");
  endtask

  task automatic test_latency();
    mon_en = 1'b0;
    direct_op(4'b0000, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 5'h13,
              64'h8000_0000_0000_0000, 1'b0);
  endtask

  task automatic test_full_ops();
    mon_en = 1'b1;
    send(4'b1000, 1'b0, 64'd5, 64'd7, 5'h01, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1);
    send(4'b0001, 1'b0, 64'd1, 64'd63, 5'h02, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
    send(4'b0001, 1'b0, 64'd1, 64'h41, 5'h03, 64'd2, 1'b0, 1'b1);
    send(4'b0011, 1'b0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 5'h04, 64'd1, 1'b0, 1'b1);
    send(4'b0010, 1'b0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 5'h05, 64'd0, 1'b0, 1'b1);
    send(4'b0101, 1'b0, 64'h8000_0000_0000_0000, 64'd4, 5'h06, 64'h0800_0000_0000_0000,
         1'b0, 1'b1);
    send(4'b1101, 1'b0, 64'h8000_0000_0000_0000, 64'd4, 5'h07, 64'hF800_0000_0000_0000,
         1'b0, 1'b1);
    send(4'b0100, 1'b0, 64'hF0F0, 64'h0FF0, 5'h08, 64'hFF00, 1'b0, 1'b1);
    send(4'b0110, 1'b0, 64'hF0F0, 64'h0FF0, 5'h09, 64'hFFF0, 1'b0, 1'b1);
    send(4'b1111, 1'b0, 64'hF0F0, 64'h0FF0, 5'h0A, 64'h00F0, 1'b0, 1'b1);
    drain();
  endtask

  task automatic test_word_ops();
    mon_en = 1'b1;
    send(4'b0000, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd1, 5'h11, 64'hFFFF_FFFF_8000_0000,
         1'b0, 1'b1);
    send(4'b1101, 1'b1, 64'h0000_0000_8000_0000, 64'h21, 5'h12, 64'hFFFF_FFFF_C000_0000,
         1'b0, 1'b1);
    send(4'b0100, 1'b1, 64'h1234, 64'h5678, 5'h13, 64'h0, 1'b1, 1'b1);
    send(4'b0010, 1'b1, 64'd1, 64'd2, 5'h14, 64'h0, 1'b1, 1'b1);
    send(4'b0001, 1'b1, 64'h0000_0000_4000_0001, 64'h21, 5'h15, 64'hFFFF_FFFF_8000_0002,
         1'b0, 1'b1);
    send(4'b0101, 1'b1, 64'hFFFF_FFFF_8000_0000, 64'd31, 5'h16, 64'd1, 1'b0, 1'b1);
    send(4'b1000, 1'b1, 64'd0, 64'd1, 5'h17, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
    drain();
  endtask

  task automatic test_back_to_back();
    int base;
    mon_en    = 1'b1;
    saw_stall = 1'b0;
    base      = popped;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          logic [63:0] a;
          logic [63:0] b;
          a = 64'(i) * 64'h0123_4567_89AB_CDEF;
          b = 64'hFFFF_0000_0000_0000 + 64'(i);
          send(4'b0000, 1'b0, a, b, 5'(8 + i), a + b, 1'b0, 1'b1);
        end
      end
      begin
        repeat (3) @(negedge clk);
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        out_ready = 1'b1;
      end
    join
    drain();
    checks++;
    if (saw_stall !== 1'b1) begin
      errors++;
      $display("FAIL b2b_in_ready_drop got saw_stall=%b exp 1", saw_stall);
    end
    checks++;
    if (popped - base != 8) begin
      errors++;
      $display("FAIL b2b_count got %0d exp 8", popped - base);
    end
  endtask

  task automatic test_flush();
    mon_en    = 1'b0;
    out_ready = 1'b0;
    send(4'b0000, 1'b0, 64'd1, 64'd2, 5'h1A, 64'd3, 1'b0, 1'b0);
    send(4'b0000, 1'b0, 64'd3, 64'd4, 5'h1B, 64'd7, 1'b0, 1'b0);
    @(negedge clk);
    alu_funct = 4'b0000;
    operand_a = 64'd10;
    operand_b = 64'd20;
    in_tag    = 5'h1C;
    in_valid  = 1'b1;
    flush     = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL flush_preload got out_valid=%b exp 1", out_valid);
    end
    @(posedge clk);
    #1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_kill got out_valid=%b exp 0", out_valid);
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL flush_residue got out_valid=%b exp 0 cycle=%0d", out_valid, i);
      end
    end
  endtask

  task automatic test_reset_mid();
    mon_en = 1'b0;
    send(4'b0000, 1'b0, 64'd100, 64'd1, 5'h1D, 64'd101, 1'b0, 1'b0);
    send(4'b0000, 1'b0, 64'd200, 64'd1, 5'h1E, 64'd201, 1'b0, 1'b0);
    @(negedge clk);
    #3;
    checks++;
    if (out_valid !== 1'b1 || out_tag !== 5'h1D) begin
      errors++;
      $display("FAIL rst_mid_preload got v=%b tag=%h exp v=1 tag=1d", out_valid, out_tag);
    end
    rst_n = 1'b0;
    #1;
    check_idle_outputs("rst_mid_async");
    @(negedge clk);
    rst_n = 1'b1;
    direct_op(4'b1000, 1'b0, 64'd10, 64'd3, 5'h1F, 64'd7, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_latency();
    test_full_ops();
    test_word_ops();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
